dvp_frame_transmitter: RTL and testbench

- Drives the transmit side of the 8-bit DVP camera interface: the same vsync/href/byte-data protocol the camera capture path receives.
- Consumes a 16-bit RGB565 pixel stream through a valid/ready handshake.
- Emits it as byte-serial DVP with programmable frame and line timing, high byte first.
- Used as a camera emulator for bench and loopback testing of the capture/DDR path, and as a DVP output to downstream boards.

---
 rtl/dvp_tx_pkg.sv | 33 +++
 rtl/dvp_frame_transmitter_if.sv | 22 ++
 rtl/dvp_tx_timing.sv | 119 +++++++++++
 rtl/dvp_frame_transmitter.sv | 77 +++++++
 tb/tb_dvp_frame_transmitter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP frame transmitter.
// No logic of its own; used by the timing generator and the top level.
// No handshake here.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } tx_state_t;

    // The high byte of each RGB565 pixel goes out first on the wire.
    localparam bit         BYTE_HI_FIRST = 1'b1;
    // Byte driven whenever href is low.
    localparam logic [7:0] BLANK_BYTE    = 8'h00;

    // Cycles per line: two byte cycles per active pixel, then the blanking.
    function automatic int line_len(input int h_pixel, input int h_blank);
        return 2 * h_pixel + h_blank;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/dvp_frame_transmitter_if.sv
// Pixel stream in (valid/ready) and the byte-serial DVP bus out.
// No latency of its own; it only bundles wires.
// pix_ready is the only back-pressure; the DVP side cannot stall.
// master: pixel source / DVP observer.  slave: the transmitter.
interface dvp_frame_transmitter_if;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic        dvp_vsync;
    logic        dvp_href;
    logic [7:0]  dvp_data;

    modport master (
        output pix_valid, pix_data,
        input  pix_ready, dvp_vsync, dvp_href, dvp_data
    );

    modport slave (
        input  pix_valid, pix_data,
        output pix_ready, dvp_vsync, dvp_href, dvp_data
    );
endinterface

// File: rtl/dvp_tx_timing.sv
// Frame/line timing generator: hcnt/vcnt counters, frame FSM, vsync/href strobes.
// vsync/href/frame_start/busy are registered and line up with the registered hcnt.
// Never stalls; slot_hi_nxt/slot_lo_nxt announce the byte slots one cycle ahead.
// Ports: sys_clk, sys_rst_n, tx_en in; vsync, href, frame_start, busy,
//        slot_hi_nxt (next cycle carries a high byte), slot_lo_nxt out.
module dvp_tx_timing
    import dvp_tx_pkg::*;
#(
    parameter int H_PIXEL     = 1024,
    parameter int V_PIXEL     = 768,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_FRONT     = 8
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic tx_en,
    output logic vsync,
    output logic href,
    output logic frame_start,
    output logic busy,
    output logic slot_hi_nxt,
    output logic slot_lo_nxt
);

    localparam int L     = line_len(H_PIXEL, H_BLANK);
    localparam int V_MAX = max4(VSYNC_LINES, V_BACK, V_PIXEL, V_FRONT);
    localparam int HW    = $clog2(L) + 1;
    localparam int VW    = $clog2(V_MAX) + 1;

    localparam logic [HW-1:0] H_LAST = HW'(L - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(2 * H_PIXEL);

    tx_state_t     state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n, v_last;
    logic          start_n;
    logic          active_n;

    // Last line index of the current region.
    always_comb begin
        v_last = '0;
        case (state)
            ST_VSYNC:  v_last = VW'(VSYNC_LINES - 1);
            ST_VBP:    v_last = VW'(V_BACK - 1);
            ST_ACTIVE: v_last = VW'(V_PIXEL - 1);
            ST_VFP:    v_last = VW'(V_FRONT - 1);
            default:   v_last = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        hcnt_n  = hcnt;
        vcnt_n  = vcnt;
        start_n = 1'b0;
        if (state == ST_IDLE) begin
            if (tx_en) begin
                state_n = ST_VSYNC;
                hcnt_n  = '0;
                vcnt_n  = '0;
                start_n = 1'b1;
            end
        end else if (hcnt == H_LAST) begin
            hcnt_n = '0;
            if (vcnt == v_last) begin
                vcnt_n = '0;
                case (state)
                    ST_VSYNC:  state_n = ST_VBP;
                    ST_VBP:    state_n = ST_ACTIVE;
                    ST_ACTIVE: state_n = ST_VFP;
                    ST_VFP: begin
                        // tx_en only matters here and in IDLE, so a frame
                        // in flight always runs to completion.
                        if (tx_en) begin
                            state_n = ST_VSYNC;
                            start_n = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end
                    default:   state_n = ST_IDLE;
                endcase
            end else begin
                vcnt_n = vcnt + VW'(1);
            end
        end else begin
            hcnt_n = hcnt + HW'(1);
        end
    end

    // Slot decode on next-cycle counters so the strobes, and pix_ready,
    // lead the registered href by exactly one cycle.
    assign active_n    = (state_n == ST_ACTIVE) && (hcnt_n < H_ACT);
    assign slot_hi_nxt = active_n && !hcnt_n[0];
    assign slot_lo_nxt = active_n &&  hcnt_n[0];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            vsync       <= 1'b0;
            href        <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            hcnt        <= hcnt_n;
            vcnt        <= vcnt_n;
            vsync       <= (state_n == ST_VSYNC);
            href        <= active_n;
            frame_start <= start_n;
            busy        <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: rtl/dvp_frame_transmitter.sv
// RGB565 pixel stream to byte-serial DVP (vsync/href/data), high byte first.
// Pixel accepted in cycle N: high byte on dvp_data at N+1, low byte at N+2.
// pix_ready is a fixed timing slot; a missing pixel sends zeros and pulses underflow.
// Ports: sys_clk, sys_rst_n, tx_en; bus (slave: pix_valid/pix_data/pix_ready,
//        dvp_vsync/dvp_href/dvp_data); frame_start, underflow, busy.
module dvp_frame_transmitter
    import dvp_tx_pkg::*;
#(
    parameter int H_PIXEL     = 1024,
    parameter int V_PIXEL     = 768,
    parameter int H_BLANK     = 64,
    parameter int VSYNC_LINES = 4,
    parameter int V_BACK      = 16,
    parameter int V_FRONT     = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic                    tx_en,
    dvp_frame_transmitter_if.slave  bus,
    output logic                    frame_start,
    output logic                    underflow,
    output logic                    busy
);

    logic        vsync_w;
    logic        href_w;
    logic        slot_hi;
    logic        slot_lo;
    logic [15:0] pix_slot;
    logic [7:0]  data_q;
    logic [7:0]  second_q;

    dvp_tx_timing #(
        .H_PIXEL     (H_PIXEL),
        .V_PIXEL     (V_PIXEL),
        .H_BLANK     (H_BLANK),
        .VSYNC_LINES (VSYNC_LINES),
        .V_BACK      (V_BACK),
        .V_FRONT     (V_FRONT)
    ) u_timing (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tx_en       (tx_en),
        .vsync       (vsync_w),
        .href        (href_w),
        .frame_start (frame_start),
        .busy        (busy),
        .slot_hi_nxt (slot_hi),
        .slot_lo_nxt (slot_lo)
    );

    // An empty slot is filled with black rather than delaying the line.
    assign pix_slot      = bus.pix_valid ? bus.pix_data : 16'h0000;
    assign bus.pix_ready = slot_hi;
    assign bus.dvp_vsync = vsync_w;
    assign bus.dvp_href  = href_w;
    assign bus.dvp_data  = data_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            data_q    <= BLANK_BYTE;
            second_q  <= 8'h00;
            underflow <= 1'b0;
        end else begin
            underflow <= slot_hi && !bus.pix_valid;
            if (slot_hi) begin
                data_q   <= BYTE_HI_FIRST ? pix_slot[15:8] : pix_slot[7:0];
                second_q <= BYTE_HI_FIRST ? pix_slot[7:0]  : pix_slot[15:8];
            end else if (slot_lo) begin
                data_q   <= second_q;
            end else begin
                data_q   <= BLANK_BYTE;
            end
        end
    end

endmodule

// File: tb/tb_dvp_frame_transmitter.sv
// Self-checking bench for dvp_frame_transmitter: frame-position reference model
// plus a byte scoreboard fed by the stimulus and drained by a negedge monitor.
// Small geometry: 12-cycle lines, 72-cycle frames.
module tb_dvp_frame_transmitter;

    localparam int HP    = 4;
    localparam int VP    = 3;
    localparam int HB    = 4;
    localparam int VS    = 1;
    localparam int VB    = 1;
    localparam int VF    = 1;
    localparam int L     = 2 * HP + HB;
    localparam int FRAME = L * (VS + VB + VP + VF);

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic tx_en     = 1'b0;
    logic frame_start, underflow, busy;

    dvp_frame_transmitter_if bus();

    dvp_frame_transmitter #(
        .H_PIXEL(HP), .V_PIXEL(VP), .H_BLANK(HB),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .tx_en       (tx_en),
        .bus         (bus),
        .frame_start (frame_start),
        .underflow   (underflow),
        .busy        (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] b;
        logic       uf;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference frame geometry by position p (cycles since frame_start).
    function automatic bit ref_vsync(input int p);
        return (p / L) < VS;
    endfunction

    function automatic bit ref_href(input int p);
        int ln;
        ln = p / L;
        return (ln >= VS + VB) && (ln < VS + VB + VP) && ((p % L) < 2 * HP);
    endfunction

    function automatic bit ref_hi_slot(input int p);
        return ref_href(p) && ((p % L) % 2 == 0);
    endfunction

    // ---------------- monitor / reference model ----------------
    bit m_run = 0, m_fs = 0, m_b2b = 0, tx_q = 0;
    int m_pos = 0;
    int cyc = 0, last_fs = -1, rdy_cnt = 0;

    always @(negedge sys_clk) begin
        bit   e_href, e_vs, e_rdy;
        exp_t e;
        cyc++;
        if (!sys_rst_n) begin
            m_run = 0; m_fs = 0; tx_q = 0; last_fs = -1; rdy_cnt = 0;
            sbq.delete();
            chk("rst_vsync",     bus.dvp_vsync, 0);
            chk("rst_href",      bus.dvp_href, 0);
            chk("rst_data",      bus.dvp_data, 0);
            chk("rst_pix_ready", bus.pix_ready, 0);
            chk("rst_fs",        frame_start, 0);
            chk("rst_underflow", underflow, 0);
            chk("rst_busy",      busy, 0);
        end else begin
            // Advance the model with the tx_en value the DUT sampled at the last edge.
            m_fs = 0;
            if (!m_run) begin
                if (tx_q) begin
                    m_run = 1; m_pos = 0; m_fs = 1; m_b2b = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == FRAME) begin
                    if (tx_q) begin
                        m_pos = 0; m_fs = 1; m_b2b = 1;
                    end else begin
                        m_run = 0;
                    end
                end
            end

            e_vs   = m_run && ref_vsync(m_pos);
            e_href = m_run && ref_href(m_pos);
            e_rdy  = m_run && (m_pos + 1 < FRAME) && ref_hi_slot(m_pos + 1);

            chk("vsync",       bus.dvp_vsync, e_vs);
            chk("href",        bus.dvp_href, e_href);
            chk("busy",        busy, m_run);
            chk("frame_start", frame_start, m_fs);
            chk("pix_ready",   bus.pix_ready, e_rdy);
            chk("sync_excl",   bus.dvp_vsync & bus.dvp_href, 0);

            if (frame_start) begin
                if (m_b2b && last_fs >= 0) begin
                    chk("fs_interval",   cyc - last_fs, FRAME);
                    chk("rdy_per_frame", rdy_cnt, HP * VP);
                end
                last_fs = cyc;
                rdy_cnt = 0;
            end
            if (bus.pix_ready) rdy_cnt++;

            if (e_href) begin
                chk("sb_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    chk("dvp_data",  bus.dvp_data, e.b);
                    chk("underflow", underflow, e.uf);
                end
            end else begin
                chk("blank_data",      bus.dvp_data, 0);
                chk("blank_underflow", underflow, 0);
            end
            tx_q = tx_en;
        end
    end

    // ---------------- stimulus ----------------
    logic [15:0] next_pix = 16'hA000;
    int vmode = 0;      // 0: always valid, 1: random, 2: drop 2nd slot of frame
    int slot_idx = 0;

    task automatic cyc_drive();
        bit v;
        @(posedge sys_clk);
        #2;
        if (frame_start) slot_idx = 0;
        case (vmode)
            1:       v = ($urandom_range(0, 3) != 0);
            2:       v = (slot_idx != 1);
            default: v = 1'b1;
        endcase
        bus.pix_valid = v;
        bus.pix_data  = next_pix;
        if (bus.pix_ready) begin
            if (v) begin
                sbq.push_back('{b: next_pix[15:8], uf: 1'b0});
                sbq.push_back('{b: next_pix[7:0],  uf: 1'b0});
                next_pix++;
            end else begin
                sbq.push_back('{b: 8'h00, uf: 1'b1});
                sbq.push_back('{b: 8'h00, uf: 1'b0});
            end
            slot_idx++;
        end
    endtask

    task automatic wait_fs(input int budget);
        int n;
        n = 0;
        do begin
            cyc_drive();
            n++;
        end while (!frame_start && n < budget);
        chk("fs_seen", frame_start, 1);
    endtask

    initial begin
        int n;
        bus.pix_valid = 1'b0;
        bus.pix_data  = 16'h0000;

        repeat (3) cyc_drive();
        sys_rst_n = 1'b1;
        repeat (2) cyc_drive();

        // Continuous frames with an always-valid incrementing source.
        tx_en = 1'b1;
        wait_fs(10);
        repeat (2 * FRAME) cyc_drive();

        // One missing pixel: second slot of the first active line.
        wait_fs(2 * FRAME);
        vmode = 2;
        repeat (FRAME - 2) cyc_drive();
        vmode = 0;

        // tx_en dropped mid-frame: frame completes, busy falls at cycle 72.
        wait_fs(2 * FRAME);
        repeat (30) cyc_drive();
        tx_en = 1'b0;
        n = 30;
        while (busy && n < 4 * FRAME) begin
            cyc_drive();
            n++;
        end
        chk("busy_fall_cycle", n, FRAME);
        repeat (20) cyc_drive();

        // Asynchronous reset while href is high.
        tx_en = 1'b1;
        n = 0;
        while (!bus.dvp_href && n < 3 * FRAME) begin
            cyc_drive();
            n++;
        end
        chk("href_before_rst", bus.dvp_href, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("rst_mid_href",  bus.dvp_href, 0);
        chk("rst_mid_vsync", bus.dvp_vsync, 0);
        chk("rst_mid_data",  bus.dvp_data, 0);
        chk("rst_mid_busy",  busy, 0);
        repeat (2) cyc_drive();
        sys_rst_n = 1'b1;
        wait_fs(10);
        repeat (FRAME) cyc_drive();

        // Random pix_valid pattern over several frames.
        vmode = 1;
        repeat (3 * FRAME) cyc_drive();
        vmode = 0;

        tx_en = 1'b0;
        n = 0;
        while (busy && n < 2 * FRAME) begin
            cyc_drive();
            n++;
        end
        repeat (5) cyc_drive();
        chk("end_idle_busy", busy, 0);
        chk("sb_drained", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
